wifi_at_sequencer: RTL and testbench

Boot-time controller that sequences the UART client's transmit path to configure the WiFi module. It walks a command table held in an external byte ROM. For each command it streams the bytes into the UART transmitter through a valid/ready handshake, then waits for the OK-detector pulse. On timeout it retries the command, up to a limit. It sits between the top-level start/status signals and the uart_tx / receiver_OK datapath, and reports progress, completion and failure.

---
 rtl/wifi_at_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_wifi_at_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_at_sequencer.sv
// wifi_at_sequencer: boot-time walker of an AT-command table held in a byte ROM.
// Each command is streamed byte by byte into the UART transmitter. The sequencer
// then waits for the OK detector, resending on timeout up to MAX_RETRY times.
//
// Handshake (tx side): tx_data/tx_valid are registered and hold steady while
// tx_valid=1 and tx_ready=0. A byte transfers on a rising edge where
// tx_valid && tx_ready. tx_ready has no effect while tx_valid=0.
module wifi_at_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned GAP_CYC     = 2500000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       iCLK,
    input  logic       RST_n,
    input  logic       start,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       ok_pulse,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] cmd_idx,
    output logic [1:0] retry_cnt,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_FETCH   = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_OK = 3'd4,
        S_DONE    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    localparam logic [25:0] TMO_LAST  = 26'(TIMEOUT_CYC - 1);
    localparam logic [25:0] GAP_LAST  = 26'(GAP_CYC - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [7:0]  LF        = 8'h0A;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  cmd_base_q, cmd_base_d;
    logic [25:0] timer_q, timer_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic [1:0]  retry_q, retry_d;

    // State and datapath registers; reset drops any byte still on offer.
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= 8'd0;
            cmd_base_q <= 8'd0;
            timer_q    <= 26'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            cmd_idx_q  <= 4'd0;
            retry_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            cmd_base_q <= cmd_base_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            cmd_idx_q  <= cmd_idx_d;
            retry_q    <= retry_d;
        end
    end

    // Next-state logic: table walk, byte handshake, OK wait with retry.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        cmd_base_d = cmd_base_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = done_q;
        fail_d     = fail_q;
        cmd_idx_d  = cmd_idx_q;
        retry_d    = retry_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                // start while busy cannot reach here, so it is ignored naturally
                if (start) begin
                    rom_addr_d = 8'd0;
                    cmd_base_d = 8'd0;
                    retry_d    = 2'd0;
                    cmd_idx_d  = 4'd0;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    timer_d    = 26'd0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    timer_d = timer_q + 26'd1;
                end
            end
            S_FETCH: begin
                if (rom_data == 8'h00) begin
                    // 0x00 at a command start ends the table; mid-command it is corrupt
                    if (rom_addr_q == cmd_base_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end
                end else begin
                    tx_data_d  = rom_data;
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (tx_data_q == LF) begin
                        timer_d = 26'd0;
                        state_d = S_WAIT_OK;
                    end else if (rom_addr_q == 8'hFF) begin
                        // a command running off the end of the ROM is not wrapped
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end else begin
                        rom_addr_d = rom_addr_q + 8'd1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WAIT_OK: begin
                // OK takes priority over a timeout landing on the same cycle
                if (ok_pulse) begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    cmd_base_d = rom_addr_q + 8'd1;
                    cmd_idx_d  = cmd_idx_q + 4'd1;
                    retry_d    = 2'd0;
                    timer_d    = 26'd0;
                    state_d    = S_GAP;
                end else if (timer_q == TMO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end else begin
                        retry_d    = retry_q + 2'd1;
                        rom_addr_d = cmd_base_q;
                        timer_d    = 26'd0;
                        state_d    = S_GAP;
                    end
                end else begin
                    timer_d = timer_q + 26'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_GAP) || (state_d == S_FETCH) ||
                 (state_d == S_SEND) || (state_d == S_WAIT_OK);
    end

    assign rom_addr    = rom_addr_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign cmd_idx     = cmd_idx_q;
    assign retry_cnt   = retry_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wifi_at_sequencer.sv
// Testbench for wifi_at_sequencer: ROM model, OK/ready responder, scoreboard of
// expected {cmd_idx, retry_cnt, byte} at every accepted byte.
module tb_wifi_at_sequencer;

  localparam int TIMEOUT_CYC = 100;
  localparam int GAP_CYC     = 4;
  localparam int MAX_RETRY   = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start = 1'b0;
  logic [7:0] rom_addr, rom_data, tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       ok_pulse = 1'b0;
  logic       busy, done, fail;
  logic [3:0] cmd_idx;
  logic [1:0] retry_cnt;
  logic [2:0] dbg_state;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  wifi_at_sequencer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .iCLK        (clk),
    .RST_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ok_pulse    (ok_pulse),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .cmd_idx     (cmd_idx),
    .retry_cnt   (retry_cnt),
    .dbg_state_o (dbg_state)
  );

  // checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [13:0] exp_q[$];
  int          hs_t[$];

  // responder controls
  int ok_delay  = 10;
  int ok_skip   = 0;
  int nl_seen   = 0;
  int ok_cd     = 0;
  bit bp_armed  = 0;
  int bp_left   = 0;
  bit ready_low = 0;
  bit ready_rand = 0;

  // responder + monitor: inputs driven and outputs sampled on the falling edge
  always @(negedge clk) begin : mon
    logic [13:0] e;
    ok_pulse = 1'b0;
    if (ok_cd > 0) begin
      ok_cd--;
      if (ok_cd == 0) ok_pulse = 1'b1;
    end
    if (ready_low) begin
      tx_ready = 1'b0;
    end else if (bp_left > 0) begin
      tx_ready = 1'b0;
      bp_left--;
      check("bp_valid", tx_valid, 1);
      check("bp_data", tx_data, 8'h54);
    end else if (bp_armed && tx_valid && tx_data == 8'h54) begin
      bp_armed = 0;
      bp_left  = 6;
      tx_ready = 1'b0;
    end else if (ready_rand) begin
      tx_ready = ($urandom_range(0, 2) != 0);
    end else begin
      tx_ready = 1'b1;
    end
    if (rst_n && tx_valid && tx_ready) begin
      hs_t.push_back(cyc + 1);
      if (exp_q.size() == 0) begin
        check("extra_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("hs_byte", {cmd_idx, retry_cnt, tx_data}, e);
      end
      if (tx_data == 8'h0A) begin
        nl_seen++;
        if (nl_seen > ok_skip) ok_cd = ok_delay;
      end
    end
  end

  // driver tasks
  task automatic push_cmd(input int base, input logic [3:0] idx, input logic [1:0] r);
    int a;
    a = base;
    while (a < 256) begin
      exp_q.push_back({idx, r, rom[a]});
      if (rom[a] == 8'h0A) break;
      a++;
    end
  endtask

  task automatic clear_test();
    exp_q.delete();
    hs_t.delete();
    nl_seen  = 0;
    ok_cd    = 0;
    ok_skip  = 0;
    ok_delay = 10;
    bp_armed = 0;
    bp_left  = 0;
    ready_rand = 0;
    ready_low  = 0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || fail) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_end", done | fail, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_cmd_idx"}, cmd_idx, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [7:0] tbl [7];
    int n;
    tbl = '{8'h41, 8'h54, 8'h0D, 8'h0A, 8'h41, 8'h0A, 8'h00};
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 7; i++) rom[i] = tbl[i];

    // reset
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal with backpressure on 0x54
    clear_test();
    bp_armed = 1;
    push_cmd(0, 4'd0, 2'd0);
    push_cmd(4, 4'd1, 2'd0);
    do_start();
    check("nom_busy_after_start", busy, 1);
    wait_end(2000);
    check("nom_done", done, 1);
    check("nom_fail", fail, 0);
    check("nom_busy", busy, 0);
    check("nom_cmd_idx", cmd_idx, 2);
    check("nom_tx_valid", tx_valid, 0);
    check("nom_q_empty", exp_q.size(), 0);
    check("nom_hs_count", hs_t.size(), 6);
    if (hs_t.size() == 6) begin
      check("nom_bp_spacing", hs_t[1] - hs_t[0], 9);
      check("nom_byte_rate", hs_t[5] - hs_t[4], 2);
      check("nom_ok_to_next", hs_t[4] - hs_t[3], 16);
    end

    // ok coincident with the last timeout cycle, plus start while busy
    clear_test();
    ok_delay = TIMEOUT_CYC;
    push_cmd(0, 4'd0, 2'd0);
    push_cmd(4, 4'd1, 2'd0);
    do_start();
    repeat (20) @(negedge clk);
    do_start();
    check("busy_start_busy", busy, 1);
    check("busy_start_idx", cmd_idx, 0);
    wait_end(2000);
    check("okedge_done", done, 1);
    check("okedge_fail", fail, 0);
    check("okedge_cmd_idx", cmd_idx, 2);
    check("okedge_q_empty", exp_q.size(), 0);
    if (hs_t.size() == 6) check("okedge_spacing", hs_t[4] - hs_t[3], TIMEOUT_CYC + GAP_CYC + 2);

    // retry then success
    clear_test();
    ok_skip = 1;
    push_cmd(0, 4'd0, 2'd0);
    push_cmd(0, 4'd0, 2'd1);
    push_cmd(4, 4'd1, 2'd0);
    do_start();
    wait_end(3000);
    check("retry_done", done, 1);
    check("retry_cmd_idx", cmd_idx, 2);
    check("retry_cnt_end", retry_cnt, 0);
    check("retry_q_empty", exp_q.size(), 0);
    check("retry_hs_count", hs_t.size(), 10);
    if (hs_t.size() == 10) check("retry_resend_spacing", hs_t[4] - hs_t[3], TIMEOUT_CYC + GAP_CYC + 2);

    // exhaustion under random ready
    clear_test();
    ok_skip = 1000;
    ready_rand = 1;
    for (int r = 0; r <= MAX_RETRY; r++) push_cmd(0, 4'd0, 2'(r));
    do_start();
    wait_end(5000);
    ready_rand = 0;
    check("exh_fail", fail, 1);
    check("exh_done", done, 0);
    check("exh_cmd_idx", cmd_idx, 0);
    check("exh_tx_valid", tx_valid, 0);
    check("exh_busy", busy, 0);
    check("exh_q_empty", exp_q.size(), 0);

    // malformed table: 0x00 mid-command
    clear_test();
    rom[2] = 8'h00;
    exp_q.push_back({4'd0, 2'd0, 8'h41});
    exp_q.push_back({4'd0, 2'd0, 8'h54});
    do_start();
    wait_end(500);
    check("mal_fail", fail, 1);
    check("mal_done", done, 0);
    check("mal_tx_valid", tx_valid, 0);
    check("mal_q_empty", exp_q.size(), 0);
    rom[2] = 8'h0D;

    // reset while a byte is on offer
    clear_test();
    ready_low = 1;
    do_start();
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstsend_reach_send", tx_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstsend");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_low = 0;
    repeat (3) @(negedge clk);
    check("rstsend_idle_busy", busy, 0);
    check("rstsend_idle_valid", tx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
